// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, synchronous ROM reads and a small
// instruction/PC buffer presented to ID over valid/ready, with redirect flush.
module if_fetch_unit #(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter int unsigned         INST_WIDTH = 32,
    parameter int unsigned         PC_STEP    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned         FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              redirect,
    input  logic [PC_WIDTH-1:0]               redirect_pc,
    output logic                              rom_ce,
    output logic [PC_WIDTH-1:0]               rom_addr,
    input  logic [INST_WIDTH-1:0]             rom_data,
    output logic                              id_valid,
    input  logic                              id_ready,
    output logic [INST_WIDTH-1:0]             id_inst,
    output logic [PC_WIDTH-1:0]               id_pc,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [PC_WIDTH-1:0]   pc;
    logic                  inflight;
    logic [PC_WIDTH-1:0]   inflight_pc;
    logic [INST_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [CW:0]           credits_used;

    // A fetch may issue only if its response is guaranteed a FIFO slot,
    // counting the outstanding response and any slot freed this cycle.
    always_comb begin
        id_valid     = (count != '0) && !redirect;
        pop          = id_valid && id_ready;
        push         = inflight && !redirect;
        credits_used = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        issue        = rst && !redirect && (credits_used < (CW+1)'(FIFO_DEPTH));
    end

    assign rom_ce     = issue;
    assign rom_addr   = pc;
    assign id_inst    = fifo_inst[rd_ptr];
    assign id_pc      = fifo_pc[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect) begin
            // Flush: buffered and in-flight work is dropped, contents left stale.
            pc       <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                pc <= pc + PC_WIDTH'(PC_STEP);
            end
            inflight    <= issue;
            inflight_pc <= pc;
            if (push) begin
                fifo_inst[wr_ptr] <= rom_data;
                fifo_pc[wr_ptr]   <= inflight_pc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
